// File: rtl/writeback.sv
// writeback: retire stage with a 2-entry input FIFO dispatching to RAM, GPR and stack.
// Define WB_RAM_TIMEOUT_EN to bound the RAM grant wait to TMO_CYC cycles and flag wb_err.
module writeback #(
  parameter int DATA_W  = 14,
  parameter int ADDR_W  = 12,
  parameter int TMO_CYC = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W+ADDR_W+3:0] complex_data,
  input  logic                     data_write,
  output logic                     pause_DECODE,
  output logic                     ram_wr,
  input  logic                     ram_garant_wr,
  output logic [ADDR_W-1:0]        addr_ram,
  output logic [DATA_W-1:0]        data_ram,
  output logic                     GPR_wr,
  output logic [ADDR_W-1:0]        addr_GPRout,
  output logic [DATA_W-1:0]        data_GPRout,
  output logic                     stack_push,
  output logic                     stack_pop,
  output logic                     halted,
  output logic                     wb_done,
  output logic                     wb_err
);
  localparam int W  = DATA_W + ADDR_W + 4;
  localparam int TW = $clog2(TMO_CYC + 1);
`ifdef WB_RAM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [3:0] OP_MOV_SR   = 4'd0;
  localparam logic [3:0] OP_INC_BIO  = 4'd1;
  localparam logic [3:0] OP_XOR_SR   = 4'd2;
  localparam logic [3:0] OP_NAND_SR  = 4'd3;
  localparam logic [3:0] OP_SRA_SR   = 4'd4;
  localparam logic [3:0] OP_XOR_BIO  = 4'd5;
  localparam logic [3:0] OP_NAND_BIO = 4'd6;
  localparam logic [3:0] OP_SRA_BIO  = 4'd7;
  localparam logic [3:0] OP_MOV_SA   = 4'd8;
  localparam logic [3:0] OP_MOV_BIO  = 4'd9;
  localparam logic [3:0] OP_INC_SR   = 4'd10;
  localparam logic [3:0] OP_POP_R    = 4'd11;
  localparam logic [3:0] OP_PUSH_R   = 4'd12;
  localparam logic [3:0] OP_HLT      = 4'd13;

  typedef enum logic [2:0] {IDLE, EXEC, RAM_WAIT, DONE, HALT} state_t;
  state_t state, state_nx;

  logic [W-1:0] fifo [2];
  logic [W-1:0] work;
  logic [1:0] count;
  logic wp, rp, push, pop;
  logic [3:0] op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic is_ram, is_gpr, exec, grant_done, tmo_hit;
  logic [TW-1:0] tmo_cnt;

  assign {data, addr, op} = work;
  assign push = data_write && count != 2'd2;
  assign pop = state == IDLE && count != 2'd0;
  assign pause_DECODE = count == 2'd2 || halted;
  assign is_ram = op inside {OP_MOV_SR, OP_INC_BIO, OP_XOR_SR, OP_NAND_SR, OP_SRA_SR,
                             OP_XOR_BIO, OP_NAND_BIO, OP_SRA_BIO};
  assign is_gpr = op inside {OP_MOV_SA, OP_MOV_BIO, OP_INC_SR, OP_POP_R};
  assign exec = state == EXEC;
  assign tmo_hit = TMO_EN && tmo_cnt == TW'(TMO_CYC - 1);
  assign grant_done = state == RAM_WAIT && (ram_garant_wr || tmo_hit);

  always_ff @(posedge clk)
    if (push) fifo[wp] <= complex_data;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      work <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      wp <= wp ^ push;
      rp <= rp ^ pop;
      if (pop) work <= fifo[rp];
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = pop ? EXEC : IDLE;
      EXEC:     state_nx = op == OP_HLT ? HALT : is_ram ? RAM_WAIT : DONE;
      RAM_WAIT: state_nx = grant_done ? DONE : RAM_WAIT;
      DONE:     state_nx = IDLE;
      default:  state_nx = state;
    endcase
  end

  // Counts grant-less cycles in RAM_WAIT; only consulted when the timeout is built in.
  always_ff @(posedge clk or negedge reset)
    if (!reset) tmo_cnt <= '0;
    else tmo_cnt <= (state == RAM_WAIT && !grant_done) ? tmo_cnt + 1'b1 : '0;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ram_wr <= 1'b0;
      addr_ram <= '0;
      data_ram <= '0;
      GPR_wr <= 1'b0;
      addr_GPRout <= '0;
      data_GPRout <= '0;
      stack_push <= 1'b0;
      stack_pop <= 1'b0;
      halted <= 1'b0;
      wb_done <= 1'b0;
      wb_err <= 1'b0;
    end else begin
      GPR_wr <= exec && is_gpr;
      stack_pop <= exec && op == OP_POP_R;
      stack_push <= exec && op == OP_PUSH_R;
      wb_done <= state == DONE;
      halted <= halted || (exec && op == OP_HLT);
      wb_err <= wb_err || (grant_done && !ram_garant_wr);
      if (exec && is_gpr) begin
        addr_GPRout <= addr;
        data_GPRout <= data;
      end
      if (exec && is_ram) begin
        ram_wr <= 1'b1;
        addr_ram <= addr;
        data_ram <= data;
      end else if (grant_done) ram_wr <= 1'b0;
    end
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed scenarios plus a randomized run scored against a queue-based retire model.
module tb_writeback;
  localparam int DW = 14;
  localparam int AW = 12;
  localparam int TMO = 15;
  localparam int N_RAND = 120;
  localparam logic [3:0] OP_MOV_SR = 4'd0;
  localparam logic [3:0] OP_MOV_SA = 4'd8;
  localparam logic [3:0] OP_MOV_BIO = 4'd9;
  localparam logic [3:0] OP_INC_SR = 4'd10;
  localparam logic [3:0] OP_HLT = 4'd13;
  typedef logic [DW+AW+3:0] word_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  word_t complex_data = '0;
  logic data_write = 1'b0;
  logic ram_garant_wr = 1'b0;
  logic pause_DECODE, ram_wr, GPR_wr, stack_push, stack_pop, halted, wb_done, wb_err;
  logic [AW-1:0] addr_ram, addr_GPRout;
  logic [DW-1:0] data_ram, data_GPRout;

  int checks = 0;
  int errors = 0;
  int gdelay = 1;
  int hi_cnt = 0;
  bit hold = 1'b0;

  writeback #(.DATA_W(DW), .ADDR_W(AW), .TMO_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .complex_data(complex_data), .data_write(data_write),
    .pause_DECODE(pause_DECODE), .ram_wr(ram_wr), .ram_garant_wr(ram_garant_wr),
    .addr_ram(addr_ram), .data_ram(data_ram), .GPR_wr(GPR_wr), .addr_GPRout(addr_GPRout),
    .data_GPRout(data_GPRout), .stack_push(stack_push), .stack_pop(stack_pop),
    .halted(halted), .wb_done(wb_done), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  // RAM grant responder: grants once ram_wr has been high for gdelay cycles, unless held off.
  initial forever begin
    @(negedge clk);
    hi_cnt = ram_wr ? hi_cnt + 1 : 0;
    ram_garant_wr = ram_wr && !hold && hi_cnt >= gdelay;
  end

  function automatic int cls(input logic [3:0] op);
    if (op <= 4'd7) return 0;
    if (op == 4'd11) return 2;
    if (op >= 4'd8 && op <= 4'd10) return 1;
    if (op == 4'd12) return 3;
    return 4;
  endfunction

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b0;
    data_write = 1'b0;
    hold = 1'b0;
    gdelay = 1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send(input logic [3:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    complex_data = {d, a, op};
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic wait_ram(input string name);
    int n = 0;
    while (!ram_wr && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ram_wr !== 1'b1) begin
      errors++;
      $display("FAIL %s: ram_wr never rose, got %b expected 1", name, ram_wr);
    end
  endtask

  task automatic test_reset;
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({pause_DECODE, ram_wr, GPR_wr, stack_push, stack_pop, halted, wb_done, wb_err,
         addr_ram, data_ram, addr_GPRout, data_GPRout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ram_wr=%b GPR_wr=%b pause=%b halted=%b expected all 0",
               ram_wr, GPR_wr, pause_DECODE, halted);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_gpr;
    apply_reset();
    send(OP_INC_SR, 12'h300, 14'h0005);
    checks++;
    if (GPR_wr !== 1'b0) begin errors++; $display("FAIL gpr_lat_n: GPR_wr got %b expected 0", GPR_wr); end
    @(negedge clk);
    checks++;
    if (GPR_wr !== 1'b0) begin errors++; $display("FAIL gpr_lat_n1: GPR_wr got %b expected 0", GPR_wr); end
    @(negedge clk);
    checks++;
    if ({GPR_wr, addr_GPRout, data_GPRout} !== {1'b1, 12'h300, 14'h0005}) begin
      errors++;
      $display("FAIL gpr_write: got wr=%b addr=%h data=%h expected wr=1 addr=300 data=0005",
               GPR_wr, addr_GPRout, data_GPRout);
    end
    @(negedge clk);
    checks++;
    if ({GPR_wr, wb_done} !== 2'b01) begin
      errors++;
      $display("FAIL gpr_done: got GPR_wr=%b wb_done=%b expected 0 1", GPR_wr, wb_done);
    end
    @(negedge clk);
    checks++;
    if (wb_done !== 1'b0) begin errors++; $display("FAIL gpr_done_pulse: wb_done got %b expected 0", wb_done); end
  endtask

  task automatic test_ram;
    int hi = 0;
    int dn = 0;
    apply_reset();
    gdelay = 3;
    send(OP_MOV_SR, 12'h0A5, 14'h1ABC);
    repeat (30) begin
      @(negedge clk);
      if (ram_wr) begin
        hi++;
        checks++;
        if ({addr_ram, data_ram} !== {12'h0A5, 14'h1ABC}) begin
          errors++;
          $display("FAIL ram_stable: got addr=%h data=%h expected 0a5 1abc", addr_ram, data_ram);
        end
      end
      dn += int'(wb_done);
    end
    checks++;
    if (hi != 3 || dn != 1) begin
      errors++;
      $display("FAIL ram_grant: got ram_wr cycles=%0d wb_done=%0d expected 3 1", hi, dn);
    end
  endtask

  task automatic test_backpressure;
    logic [AW-1:0] ga [$];
    int dn = 0;
    apply_reset();
    hold = 1'b1;
    send(OP_MOV_SR, 12'h011, 14'h0101);
    wait_ram("bp_ram");
    complex_data = {14'h0B0B, 12'h0B1, OP_MOV_SA};
    data_write = 1'b1;
    @(negedge clk);
    checks++;
    if (pause_DECODE !== 1'b0) begin errors++; $display("FAIL bp_pause1: got %b expected 0", pause_DECODE); end
    complex_data = {14'h0C0C, 12'h0C1, OP_MOV_SA};
    @(negedge clk);
    checks++;
    if (pause_DECODE !== 1'b1) begin errors++; $display("FAIL bp_pause2: got %b expected 1", pause_DECODE); end
    complex_data = {14'h0D0D, 12'h0D1, OP_MOV_BIO};
    @(negedge clk);
    data_write = 1'b0;
    checks++;
    if (pause_DECODE !== 1'b1) begin errors++; $display("FAIL bp_pause3: got %b expected 1", pause_DECODE); end
    hold = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (GPR_wr) ga.push_back(addr_GPRout);
      dn += int'(wb_done);
    end
    checks++;
    if (ga.size() != 2 || dn != 3) begin
      errors++;
      $display("FAIL bp_count: got gpr writes=%0d wb_done=%0d expected 2 3", ga.size(), dn);
    end else begin
      checks++;
      if (ga[0] !== 12'h0B1 || ga[1] !== 12'h0C1) begin
        errors++;
        $display("FAIL bp_order: got %h %h expected 0b1 0c1", ga[0], ga[1]);
      end
    end
  endtask

  task automatic test_halt;
    int g = 0;
    apply_reset();
    send(OP_HLT, 12'h000, 14'h0000);
    send(OP_MOV_SA, 12'h055, 14'h0055);
    repeat (15) begin
      @(negedge clk);
      g += int'(GPR_wr);
    end
    checks++;
    if ({halted, pause_DECODE, ram_wr} !== 3'b110 || g != 0) begin
      errors++;
      $display("FAIL halt: got halted=%b pause=%b ram_wr=%b gpr writes=%0d expected 1 1 0 0",
               halted, pause_DECODE, ram_wr, g);
    end
  endtask

  task automatic test_reset_mid;
    int g = 0;
    int dn = 0;
    apply_reset();
    hold = 1'b1;
    send(OP_MOV_SR, 12'h123, 14'h0321);
    wait_ram("rm_ram");
    send(OP_MOV_SA, 12'h201, 14'h0201);
    send(OP_MOV_SA, 12'h202, 14'h0202);
    checks++;
    if (pause_DECODE !== 1'b1) begin errors++; $display("FAIL rm_full: pause got %b expected 1", pause_DECODE); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ram_wr, pause_DECODE} !== 2'b00) begin
      errors++;
      $display("FAIL rm_async: got ram_wr=%b pause=%b expected 0 0", ram_wr, pause_DECODE);
    end
    @(negedge clk);
    reset = 1'b1;
    hold = 1'b0;
    send(OP_INC_SR, 12'h3A3, 14'h2A2A);
    repeat (20) begin
      @(negedge clk);
      if (GPR_wr) begin
        g++;
        checks++;
        if ({addr_GPRout, data_GPRout} !== {12'h3A3, 14'h2A2A}) begin
          errors++;
          $display("FAIL rm_gpr: got addr=%h data=%h expected 3a3 2a2a", addr_GPRout, data_GPRout);
        end
      end
      dn += int'(wb_done);
    end
    checks++;
    if (g != 1 || dn != 1) begin
      errors++;
      $display("FAIL rm_resume: got gpr writes=%0d wb_done=%0d expected 1 1", g, dn);
    end
  endtask

`ifdef WB_RAM_TIMEOUT_EN
  task automatic test_timeout;
    int hi = 0;
    int dn = 0;
    apply_reset();
    hold = 1'b1;
    send(OP_MOV_SR, 12'h0F0, 14'h0F0F);
    repeat (40) begin
      @(negedge clk);
      hi += int'(ram_wr);
      dn += int'(wb_done);
    end
    checks++;
    if (hi != TMO || dn != 1 || wb_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout: got ram_wr cycles=%0d wb_done=%0d wb_err=%b expected %0d 1 1",
               hi, dn, wb_err, TMO);
    end
    hold = 1'b0;
  endtask
`endif

  task automatic test_random;
    word_t q [$];
    word_t e;
    int n_done = 0;
    int seen_ram = 0, n_gpr = 0, n_push = 0, n_pop = 0, c;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    logic [3:0] op;
    apply_reset();
    fork
      begin
        for (int i = 0; i < N_RAND;) begin
          @(negedge clk);
          if (!pause_DECODE && $urandom_range(0, 2) != 0) begin
            op = 4'($urandom_range(0, 15));
            if (op == OP_HLT) op = 4'd14;
            complex_data = {DW'($urandom), AW'($urandom), op};
            data_write = 1'b1;
            q.push_back(complex_data);
            i++;
          end else data_write = 1'b0;
        end
        @(negedge clk);
        data_write = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 8000 && n_done < N_RAND; cyc++) begin
          @(negedge clk);
          if (ram_wr) begin
            seen_ram = 1;
            checks++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL rnd_ram: ram_wr with no word pending, got 1 expected 0");
            end else begin
              e = q[0];
              if ({addr_ram, data_ram} !== {e[AW+3:4], e[DW+AW+3:AW+4]}) begin
                errors++;
                $display("FAIL rnd_ram: got addr=%h data=%h expected %h %h",
                         addr_ram, data_ram, e[AW+3:4], e[DW+AW+3:AW+4]);
              end
            end
          end
          if (GPR_wr) begin
            n_gpr++;
            ga = addr_GPRout;
            gd = data_GPRout;
          end
          n_push += int'(stack_push);
          n_pop += int'(stack_pop);
          if (wb_done) begin
            checks++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL rnd_done: wb_done with no word pending, got 1 expected 0");
            end else begin
              e = q.pop_front();
              c = cls(e[3:0]);
              if (seen_ram != int'(c == 0) || n_gpr != int'(c == 1 || c == 2) ||
                  n_push != int'(c == 3) || n_pop != int'(c == 2)) begin
                errors++;
                $display("FAIL rnd_effect: op=%0d got ram=%0d gpr=%0d push=%0d pop=%0d expected %0d %0d %0d %0d",
                         e[3:0], seen_ram, n_gpr, n_push, n_pop,
                         c == 0, c == 1 || c == 2, c == 3, c == 2);
              end else if (c == 1 || c == 2) begin
                checks++;
                if ({ga, gd} !== {e[AW+3:4], e[DW+AW+3:AW+4]}) begin
                  errors++;
                  $display("FAIL rnd_gpr: got addr=%h data=%h expected %h %h",
                           ga, gd, e[AW+3:4], e[DW+AW+3:AW+4]);
                end
              end
            end
            seen_ram = 0;
            n_gpr = 0;
            n_push = 0;
            n_pop = 0;
            n_done++;
            gdelay = $urandom_range(1, 4);
          end
        end
      end
    join
    checks++;
    if (n_done != N_RAND || q.size() != 0) begin
      errors++;
      $display("FAIL rnd_total: got retired=%0d pending=%0d expected %0d 0", n_done, q.size(), N_RAND);
    end
  endtask

  initial begin
    test_reset();
    test_gpr();
    test_ram();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef WB_RAM_TIMEOUT_EN
    test_timeout();
`endif
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
